redmule_inst_queue_decoder: RTL and testbench

Parametrised successor of the RedMulE offload instruction decoder.
- Decodes instructions offloaded by the core: MCNFIG, MARITH and CSR-range checks.
- Buffers up to QueueDepth complete job descriptors in a FIFO, so the core can issue job N+1 while job N is being programmed or is running.
- Drains each descriptor as NumCfgRegs register writes on the controller cfg port, followed by a start pulse and a trigger write.

---
 rtl/redmule_pkg.sv | 23 ++
 rtl/redmule_desc_fifo.sv | 65 ++++++
 rtl/redmule_inst_queue_decoder.sv | 181 ++++++++++++++++++
 tb/tb_redmule_inst_queue_decoder.sv | 435 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/redmule_pkg.sv
// RedMulE shared definitions: offload opcodes, CSR window,
// job descriptor type and queue-decoder FSM states.
package redmule_pkg;

  localparam logic [6:0] MCNFIG = 7'b0001011;
  localparam logic [6:0] MARITH = 7'b0101011;
  localparam logic [6:0] RVCSR  = 7'b1110011;

  localparam logic [11:0] CSR_REDMULE_MACFG = 12'hBC0;

  localparam int unsigned DefDataWidth  = 32;
  localparam int unsigned DefNumCfgRegs = 6;

  typedef logic [DefNumCfgRegs-1:0][DefDataWidth-1:0] redmule_job_desc_t;

  typedef enum logic [1:0] {
    Idle,
    Load,
    WriteCfg,
    Trigger
  } redmule_qdec_state_e;

endpackage

// File: rtl/redmule_desc_fifo.sv
// Sync FIFO of job descriptors, any depth >= 1.
// Ports: push_i/data_i in, pop_i/data_o out, full_o, empty_o, count_o.
module redmule_desc_fifo #(
  parameter int unsigned Width = 192,
  parameter int unsigned Depth = 4,
  localparam int unsigned CntW = $clog2(Depth+1)
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            clear_i,
  input  logic            push_i,
  input  logic [Width-1:0] data_i,
  input  logic            pop_i,
  output logic [Width-1:0] data_o,
  output logic            full_o,
  output logic            empty_o,
  output logic [CntW-1:0] count_o
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_q, wr_d;
  logic [PtrW-1:0]  rd_q, rd_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             do_push, do_pop;

  // Pointers wrap explicitly so non-power-of-2 depths work.
  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(Depth-1)) ? '0 : p + PtrW'(1);
  endfunction

  assign full_o  = (cnt_q == CntW'(Depth));
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;
  assign data_o  = mem_q[rd_q];

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_comb begin
    wr_d  = do_push ? ptr_inc(wr_q) : wr_q;
    rd_d  = do_pop ? ptr_inc(rd_q) : rd_q;
    cnt_d = cnt_q;
    if (do_push && !do_pop) cnt_d = cnt_q + CntW'(1);
    if (!do_push && do_pop) cnt_d = cnt_q - CntW'(1);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_q] <= data_i;
  end

endmodule

// File: rtl/redmule_inst_queue_decoder.sv
// Offload decoder with a job-descriptor queue; drains each job as
// cfg writes, a start pulse and a trigger write. Ports: issue_*, cfg_*.
module redmule_inst_queue_decoder
  import redmule_pkg::*;
#(
  parameter int unsigned SysDataWidth = 32,
  parameter int unsigned NumRsPorts   = 3,
  parameter int unsigned NumCfgRegs   = 6,
  parameter int unsigned QueueDepth   = 4,
  parameter logic [31:0] CfgBaseAddr  = 32'h40,
  parameter logic [31:0] TriggerAddr  = 32'h0,
  parameter logic [11:0] CsrLo        = CSR_REDMULE_MACFG,
  parameter logic [11:0] CsrHi        = CSR_REDMULE_MACFG,
  localparam int unsigned CntW = $clog2(QueueDepth+1)
) (
  input  logic                               clk_i,
  input  logic                               rst_i,
  input  logic                               clear_i,
  input  logic                               issue_valid_i,
  output logic                               issue_ready_o,
  output logic                               issue_accept_o,
  input  logic [31:0]                        issue_instr_i,
  input  logic [NumRsPorts*SysDataWidth-1:0] issue_rs_i,
  input  logic [NumRsPorts-1:0]              issue_rs_valid_i,
  output logic                               cfg_req_o,
  output logic [31:0]                        cfg_add_o,
  output logic [SysDataWidth-1:0]            cfg_data_o,
  output logic                               cfg_wen_o,
  output logic [SysDataWidth/8-1:0]          cfg_be_o,
  input  logic                               cfg_gnt_i,
  input  logic                               cfg_complete_i,
  output logic                               start_cfg_o,
  output logic [CntW-1:0]                    queue_count_o,
  output logic                               busy_o
);

  localparam int unsigned IdxW  = $clog2(NumCfgRegs);
  localparam int unsigned DescW = NumCfgRegs*SysDataWidth;

  typedef logic [NumCfgRegs-1:0][SysDataWidth-1:0] desc_t;

  redmule_qdec_state_e state_q, state_d;
  logic [IdxW-1:0]     idx_q, idx_d;
  desc_t               desc_q, desc_d;
  desc_t               push_desc;
  logic [SysDataWidth-1:0] mk_q, n_q;
  logic [DescW-1:0]    fifo_rdata;
  logic                fifo_full, fifo_empty;
  logic                push, pop, stage_load;
  logic                is_mcnfig, is_marith, is_csr;
  logic [SysDataWidth-1:0] rs0, rs1, rs2;

  assign rs0 = issue_rs_i[0*SysDataWidth +: SysDataWidth];
  assign rs1 = issue_rs_i[1*SysDataWidth +: SysDataWidth];
  assign rs2 = issue_rs_i[2*SysDataWidth +: SysDataWidth];

  assign is_mcnfig = (issue_instr_i[6:0] == MCNFIG);
  assign is_marith = (issue_instr_i[6:0] == MARITH);
  assign is_csr    = (issue_instr_i[6:0] == RVCSR);

  always_comb begin
    issue_ready_o  = 1'b0;
    issue_accept_o = 1'b0;
    stage_load     = 1'b0;
    push           = 1'b0;
    if (issue_valid_i) begin
      unique case (1'b1)
        is_mcnfig: begin
          issue_ready_o  = &issue_rs_valid_i[1:0];
          issue_accept_o = issue_ready_o;
          stage_load     = issue_ready_o;
        end
        is_marith: begin
          issue_ready_o  = &issue_rs_valid_i[2:0] && !fifo_full;
          issue_accept_o = issue_ready_o;
          push           = issue_ready_o;
        end
        is_csr: begin
          issue_ready_o  = 1'b1;
          issue_accept_o = (issue_instr_i[31:20] >= CsrLo) &&
                           (issue_instr_i[31:20] <= CsrHi);
        end
        default: issue_ready_o = 1'b1;
      endcase
    end
  end

  always_comb begin
    push_desc    = '0;
    push_desc[0] = rs0;
    push_desc[1] = rs1;
    push_desc[2] = rs2;
    push_desc[3] = mk_q;
    push_desc[4] = n_q;
    push_desc[5] = SysDataWidth'(issue_instr_i);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      mk_q <= '0;
      n_q  <= '0;
    end else if (stage_load) begin
      mk_q <= rs0;
      n_q  <= rs1;
    end
  end

  redmule_desc_fifo #(
    .Width (DescW),
    .Depth (QueueDepth)
  ) i_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clear_i (clear_i),
    .push_i  (push),
    .data_i  (push_desc),
    .pop_i   (pop),
    .data_o  (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (queue_count_o)
  );

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    desc_d      = desc_q;
    pop         = 1'b0;
    cfg_req_o   = 1'b0;
    cfg_add_o   = '0;
    cfg_data_o  = '0;
    start_cfg_o = 1'b0;
    unique case (state_q)
      Idle: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          desc_d  = fifo_rdata;
          state_d = Load;
        end
      end
      Load: state_d = WriteCfg;
      WriteCfg: begin
        cfg_req_o  = 1'b1;
        cfg_add_o  = CfgBaseAddr + (32'(idx_q) << 2);
        cfg_data_o = desc_q[idx_q];
        if (cfg_gnt_i) begin
          if (idx_q == IdxW'(NumCfgRegs-1)) begin
            start_cfg_o = 1'b1;
            idx_d       = '0;
            state_d     = Trigger;
          end else begin
            idx_d = idx_q + IdxW'(1);
          end
        end
      end
      Trigger: begin
        cfg_req_o = cfg_complete_i;
        cfg_add_o = TriggerAddr;
        if (cfg_complete_i && cfg_gnt_i) state_d = Idle;
      end
      default: state_d = Idle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      state_q <= Idle;
      idx_q   <= '0;
      desc_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      desc_q  <= desc_d;
    end
  end

  assign cfg_wen_o = 1'b0;
  assign cfg_be_o  = '1;
  assign busy_o    = !fifo_empty || (state_q != Idle);

endmodule

// File: tb/tb_redmule_inst_queue_decoder.sv
// Self-checking bench for redmule_inst_queue_decoder.
// Scoreboard of expected cfg writes, checked on every granted request.
module tb_redmule_inst_queue_decoder;
  import redmule_pkg::*;

  localparam int W  = 32;
  localparam int NR = 3;

  logic          clk = 1'b0;
  logic          rst, clear;
  logic          issue_valid, issue_ready, issue_accept;
  logic [31:0]   issue_instr;
  logic [NR*W-1:0] issue_rs;
  logic [NR-1:0] issue_rs_valid;
  logic          cfg_req, cfg_wen, cfg_gnt, cfg_complete, start_cfg, busy;
  logic [31:0]   cfg_add;
  logic [W-1:0]  cfg_data;
  logic [W/8-1:0] cfg_be;
  logic [2:0]    queue_count;

  int vectors = 0;
  int errors  = 0;

  logic [63:0] sb[$];
  logic [31:0] mk_m, n_m;

  logic        prev_pend;
  logic [31:0] prev_add, prev_data;
  logic [63:0] mon_e;
  logic        mon_start;

  always #5 clk = ~clk;

  redmule_inst_queue_decoder dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .clear_i          (clear),
    .issue_valid_i    (issue_valid),
    .issue_ready_o    (issue_ready),
    .issue_accept_o   (issue_accept),
    .issue_instr_i    (issue_instr),
    .issue_rs_i       (issue_rs),
    .issue_rs_valid_i (issue_rs_valid),
    .cfg_req_o        (cfg_req),
    .cfg_add_o        (cfg_add),
    .cfg_data_o       (cfg_data),
    .cfg_wen_o        (cfg_wen),
    .cfg_be_o         (cfg_be),
    .cfg_gnt_i        (cfg_gnt),
    .cfg_complete_i   (cfg_complete),
    .start_cfg_o      (start_cfg),
    .queue_count_o    (queue_count),
    .busy_o           (busy)
  );

  always @(negedge clk) begin
    mon_start = 1'b0;
    if (!rst && !clear) begin
      if (cfg_req && cfg_gnt) begin
        vectors++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL sb_unexpected: add=%h data=%h, required no write",
                   cfg_add, cfg_data);
        end else begin
          mon_e = sb.pop_front();
          mon_start = (mon_e[63:32] == 32'h54);
          if ({cfg_add, cfg_data} !== mon_e) begin
            errors++;
            $display("FAIL cfg_write: add=%h data=%h, required add=%h data=%h",
                     cfg_add, cfg_data, mon_e[63:32], mon_e[31:0]);
          end
        end
      end
      vectors++;
      if (start_cfg !== mon_start) begin
        errors++;
        $display("FAIL start_cfg: got %b, required %b", start_cfg, mon_start);
      end
      if (prev_pend && cfg_req) begin
        vectors++;
        if (cfg_add !== prev_add || cfg_data !== prev_data) begin
          errors++;
          $display("FAIL hold: add=%h data=%h, required add=%h data=%h",
                   cfg_add, cfg_data, prev_add, prev_data);
        end
      end
      prev_pend = cfg_req && !cfg_gnt;
      prev_add  = cfg_add;
      prev_data = cfg_data;
    end else begin
      prev_pend = 1'b0;
    end
  end

  task automatic set_issue(input logic [31:0] ins, input logic [31:0] r0,
                           input logic [31:0] r1, input logic [31:0] r2,
                           input logic [2:0] rsv);
    issue_valid    = 1'b1;
    issue_instr    = ins;
    issue_rs       = {r2, r1, r0};
    issue_rs_valid = rsv;
  endtask

  task automatic do_issue(input logic [31:0] ins, input logic [31:0] r0,
                          input logic [31:0] r1, input logic [31:0] r2,
                          input logic [2:0] rsv, input int budget,
                          output logic acc);
    logic ok;
    logic [31:0] w [6];
    set_issue(ins, r0, r1, r2, rsv);
    ok  = 1'b0;
    acc = 1'b0;
    for (int c = 0; c < budget && !ok; c++) begin
      @(negedge clk);
      if (issue_ready) begin
        ok  = 1'b1;
        acc = issue_accept;
        if (acc && ins[6:0] == MARITH) begin
          w = '{r0, r1, r2, mk_m, n_m, ins};
          for (int i = 0; i < 6; i++)
            sb.push_back({32'h40 + 32'(4*i), w[i]});
          sb.push_back(64'h0);
        end
        if (acc && ins[6:0] == MCNFIG) begin
          mk_m = r0;
          n_m  = r1;
        end
      end
      @(posedge clk); #1;
    end
    issue_valid = 1'b0;
    vectors++;
    if (!ok) begin
      errors++;
      $display("FAIL issue_timeout: ready=0 for %0d cycles, required 1", budget);
    end
  endtask

  task automatic wait_drain(input int budget);
    logic done;
    done = 1'b0;
    for (int c = 0; c < budget && !done; c++) begin
      @(negedge clk);
      if (sb.size() == 0 && !busy) done = 1'b1;
    end
    vectors++;
    if (!done) begin
      errors++;
      $display("FAIL drain_timeout: %0d writes left busy=%b, required 0/0",
               sb.size(), busy);
    end
    @(posedge clk); #1;
  endtask

  task automatic model_reset();
    sb.delete();
    mk_m = '0;
    n_m  = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1; clear = 1'b0;
    issue_valid = 1'b0; issue_instr = '0; issue_rs = '0;
    issue_rs_valid = '0; cfg_gnt = 1'b0; cfg_complete = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    vectors++;
    if ({issue_ready, issue_accept, cfg_req, start_cfg, busy, cfg_wen} !== 6'b0) begin
      errors++;
      $display("FAIL reset_ctrl: rdy/acc/req/start/busy/wen=%b, required 000000",
               {issue_ready, issue_accept, cfg_req, start_cfg, busy, cfg_wen});
    end
    vectors++;
    if (cfg_add !== 32'h0 || cfg_data !== 32'h0 || queue_count !== 3'd0) begin
      errors++;
      $display("FAIL reset_data: add=%h data=%h cnt=%0d, required 0/0/0",
               cfg_add, cfg_data, queue_count);
    end
    vectors++;
    if (cfg_be !== 4'hF) begin
      errors++;
      $display("FAIL reset_be: got %h, required f", cfg_be);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    logic acc;
    logic [31:0] mar;
    mar = {25'h0123456 , MARITH};
    cfg_gnt = 1'b1; cfg_complete = 1'b1;
    do_issue({25'h0, MCNFIG}, 32'h0010_0020, 32'h40, 32'h0, 3'b011, 5, acc);
    vectors++;
    if (acc !== 1'b1) begin
      errors++; $display("FAIL mcnfig_accept: got %b, required 1", acc);
    end
    do_issue(mar, 32'h1000, 32'h2000, 32'h3000, 3'b111, 1, acc);
    vectors++;
    if (acc !== 1'b1) begin
      errors++; $display("FAIL marith_accept: got %b, required 1", acc);
    end
    @(negedge clk);
    vectors++;
    if (cfg_req !== 1'b0 || queue_count !== 3'd1) begin
      errors++;
      $display("FAIL latency_t1: req=%b cnt=%0d, required 0/1", cfg_req, queue_count);
    end
    @(negedge clk);
    vectors++;
    if (cfg_req !== 1'b0) begin
      errors++; $display("FAIL latency_t2: req=%b, required 0", cfg_req);
    end
    @(negedge clk);
    vectors++;
    if (cfg_req !== 1'b1) begin
      errors++; $display("FAIL latency_t3: req=%b, required 1", cfg_req);
    end
    @(posedge clk); #1;
    wait_drain(40);
  endtask

  task automatic test_reset_mid();
    logic acc;
    int g;
    cfg_gnt = 1'b0; cfg_complete = 1'b1;
    do_issue({25'h0, MCNFIG}, 32'h5, 32'h6, 32'h0, 3'b011, 5, acc);
    do_issue({25'h7, MARITH}, 32'h11, 32'h22, 32'h33, 3'b111, 5, acc);
    cfg_gnt = 1'b1;
    g = 0;
    for (int c = 0; c < 30 && g < 2; c++) begin
      @(negedge clk);
      if (cfg_req && cfg_gnt) g++;
      if (g < 2) begin @(posedge clk); #1; end
    end
    vectors++;
    if (g != 2) begin
      errors++; $display("FAIL mid_grants: got %0d, required 2", g);
    end
    @(posedge clk); #1;
    cfg_gnt = 1'b0; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    @(negedge clk);
    vectors++;
    if (cfg_req !== 1'b0 || queue_count !== 3'd0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: req=%b cnt=%0d busy=%b, required 0/0/0",
               cfg_req, queue_count, busy);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_clear();
    logic acc;
    cfg_gnt = 1'b0; cfg_complete = 1'b1;
    do_issue({25'h0, MCNFIG}, 32'h77, 32'h88, 32'h0, 3'b011, 5, acc);
    do_issue({25'h9, MARITH}, 32'h1, 32'h2, 32'h3, 3'b111, 5, acc);
    do_issue({25'hA, MARITH}, 32'h4, 32'h5, 32'h6, 3'b111, 5, acc);
    repeat (3) @(posedge clk);
    #1 clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    model_reset();
    @(negedge clk);
    vectors++;
    if (cfg_req !== 1'b0 || queue_count !== 3'd0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL clear: req=%b cnt=%0d busy=%b, required 0/0/0",
               cfg_req, queue_count, busy);
    end
    @(posedge clk); #1;
    cfg_gnt = 1'b1;
    do_issue({25'hB, MARITH}, 32'hA1, 32'hA2, 32'hA3, 3'b111, 5, acc);
    wait_drain(40);
  endtask

  task automatic test_back_to_back();
    logic acc;
    logic got;
    cfg_gnt = 1'b0; cfg_complete = 1'b1;
    do_issue({25'h100, MARITH}, 32'h100, 32'h101, 32'h102, 3'b111, 5, acc);
    got = 1'b0;
    for (int c = 0; c < 10 && !got; c++) begin
      @(negedge clk);
      got = cfg_req;
    end
    @(posedge clk); #1;
    for (int j = 1; j <= 4; j++)
      do_issue({25'h100 + 25'(j), MARITH}, 32'(j*16), 32'(j*16+1),
               32'(j*16+2), 3'b111, 1, acc);
    @(negedge clk);
    vectors++;
    if (queue_count !== 3'd4) begin
      errors++; $display("FAIL fifo_full_count: got %0d, required 4", queue_count);
    end
    @(posedge clk); #1;
    set_issue({25'h105, MARITH}, 32'h500, 32'h501, 32'h502, 3'b111);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      vectors++;
      if (issue_ready !== 1'b0) begin
        errors++; $display("FAIL full_stall: ready=%b, required 0", issue_ready);
      end
    end
    @(posedge clk); #1;
    cfg_gnt = 1'b1;
    do_issue({25'h105, MARITH}, 32'h500, 32'h501, 32'h502, 3'b111, 60, acc);
    vectors++;
    if (acc !== 1'b1) begin
      errors++; $display("FAIL fifth_accept: got %b, required 1", acc);
    end
    wait_drain(120);
  endtask

  task automatic test_rs_valid();
    logic acc;
    cfg_gnt = 1'b1; cfg_complete = 1'b1;
    set_issue({25'h200, MARITH}, 32'hC0, 32'hC1, 32'hC2, 3'b011);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      vectors++;
      if (issue_ready !== 1'b0 || queue_count !== 3'd0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL rs_stall: ready=%b cnt=%0d busy=%b, required 0/0/0",
                 issue_ready, queue_count, busy);
      end
    end
    @(posedge clk); #1;
    do_issue({25'h200, MARITH}, 32'hC0, 32'hC1, 32'hC2, 3'b111, 1, acc);
    vectors++;
    if (acc !== 1'b1) begin
      errors++; $display("FAIL rs_accept: got %b, required 1", acc);
    end
    wait_drain(40);
    set_issue({25'h0, MCNFIG}, 32'hD0, 32'hD1, 32'h0, 3'b001);
    @(negedge clk);
    vectors++;
    if (issue_ready !== 1'b0) begin
      errors++; $display("FAIL mcnfig_stall: ready=%b, required 0", issue_ready);
    end
    @(posedge clk); #1;
    do_issue({25'h0, MCNFIG}, 32'hD0, 32'hD1, 32'h0, 3'b011, 1, acc);
    do_issue({25'h201, MARITH}, 32'hE0, 32'hE1, 32'hE2, 3'b111, 1, acc);
    wait_drain(40);
  endtask

  task automatic test_csr();
    logic acc;
    do_issue({CSR_REDMULE_MACFG, 5'd0, 3'b010, 5'd1, RVCSR}, 0, 0, 0, 3'b000, 1, acc);
    vectors++;
    if (acc !== 1'b1) begin
      errors++; $display("FAIL csr_in: accept=%b, required 1", acc);
    end
    do_issue({12'h300, 5'd0, 3'b010, 5'd1, RVCSR}, 0, 0, 0, 3'b000, 1, acc);
    vectors++;
    if (acc !== 1'b0) begin
      errors++; $display("FAIL csr_out: accept=%b, required 0", acc);
    end
    do_issue({25'h0, 7'h33}, 0, 0, 0, 3'b111, 1, acc);
    vectors++;
    if (acc !== 1'b0) begin
      errors++; $display("FAIL other_op: accept=%b, required 0", acc);
    end
    issue_instr = {25'h0, MARITH};
    issue_rs_valid = 3'b111;
    @(negedge clk);
    vectors++;
    if (issue_ready !== 1'b0 || issue_accept !== 1'b0) begin
      errors++;
      $display("FAIL no_valid: ready=%b accept=%b, required 0/0",
               issue_ready, issue_accept);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_random_gnt();
    logic acc;
    logic seen;
    int g;
    cfg_gnt = 1'b0; cfg_complete = 1'b0;
    do_issue({25'h300, MARITH}, 32'hF0, 32'hF1, 32'hF2, 3'b111, 1, acc);
    g = 0;
    seen = 1'b0;
    for (int c = 0; c < 300 && !seen; c++) begin
      @(posedge clk); #1;
      cfg_gnt = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (cfg_req && cfg_gnt && cfg_add >= 32'h40 && cfg_add <= 32'h54) g++;
      if (start_cfg) seen = 1'b1;
    end
    vectors++;
    if (g != 6 || !seen) begin
      errors++;
      $display("FAIL grant_count: grants=%0d start=%b, required 6/1", g, seen);
    end
    @(posedge clk); #1;
    cfg_gnt = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      vectors++;
      if (cfg_req !== 1'b0 || busy !== 1'b1) begin
        errors++;
        $display("FAIL trig_wait: req=%b busy=%b, required 0/1", cfg_req, busy);
      end
    end
    @(posedge clk); #1;
    cfg_complete = 1'b1;
    wait_drain(20);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    prev_pend = 1'b0;
    test_reset();
    test_basic();
    test_reset_mid();
    test_clear();
    test_back_to_back();
    test_rs_valid();
    test_csr();
    test_random_gnt();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
